// File: rtl/mio_pkg.sv
// Shared types and constants for the memory/IO responder and its address decoder.
package mio_pkg;

    // Top nibble of a byte address that selects the IO window.
    localparam logic [3:0] IO_BASE_NIBBLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        RAM,
        IO,
        NONE
    } tgt_t;

endpackage

// File: rtl/mio_bus_if.sv
// CPU-side memory bus: request strobe, direction, address/data and completion.
// Optional MIO_BUS_ERR_EN adds the bus_err completion flag.
interface mio_bus_if;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        MIO_ready;
`ifdef MIO_BUS_ERR_EN
    logic        bus_err;

    modport master (output CPU_MIO, mem_w, addr, data_in,
                    input  data_out, MIO_ready, bus_err);
    modport slave  (input  CPU_MIO, mem_w, addr, data_in,
                    output data_out, MIO_ready, bus_err);
`else
    modport master (output CPU_MIO, mem_w, addr, data_in,
                    input  data_out, MIO_ready);
    modport slave  (input  CPU_MIO, mem_w, addr, data_in,
                    output data_out, MIO_ready);
`endif
endinterface

// File: rtl/mio_addr_decode.sv
// Combinational byte-address decoder: target select plus RAM/IO word addresses.
// With MIO_BUS_ERR_EN, non-IO addresses above the RAM window decode to NONE;
// otherwise they alias into RAM through truncation.
module mio_addr_decode
    import mio_pkg::*;
#(
    parameter int RAM_AW = 10,
    parameter int IO_AW  = 4
) (
    input  logic [31:0]       addr,
    output tgt_t              sel,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [IO_AW-1:0]  io_addr
);

    // Byte-lane bits and (in the default build) the truncated upper bits are
    // deliberately ignored.
    logic unused_addr;

    assign ram_addr    = addr[RAM_AW+1:2];
    assign io_addr     = addr[IO_AW+1:2];
    assign unused_addr = ^addr;

    // Window select from the top nibble, then (optionally) the RAM range check.
    always_comb begin
        sel = RAM;
        if (addr[31:28] == IO_BASE_NIBBLE) begin
            sel = IO;
        end
`ifdef MIO_BUS_ERR_EN
        else if ((addr >> (RAM_AW + 2)) != 32'd0) begin
            sel = NONE;
        end
`endif
    end

endmodule

// File: rtl/mio_responder.sv
// Memory/IO responder: target side of the CPU_MIO / mem_w / MIO_ready handshake.
// Optional feature macro: MIO_BUS_ERR_EN (unmapped-address detection, bus_err).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for CPU_MIO; request fields latched on acceptance
// ACCESS | one-cycle strobe to the selected RAM or IO port
// WAIT   | counting down the target's extra wait cycles
// RESP   | one-cycle MIO_ready pulse; read data already captured
module mio_responder
    import mio_pkg::*;
#(
    parameter int RAM_AW   = 10,
    parameter int IO_AW    = 4,
    parameter int RAM_WAIT = 0,
    parameter int IO_WAIT  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    mio_bus_if.slave          bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_en,
    output logic              io_we,
    output logic [IO_AW-1:0]  io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata
);

    localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);
    localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

    state_t            state_q, state_d;
    tgt_t              dec_sel, sel_q;
    logic [RAM_AW-1:0] dec_ram_addr, ram_addr_q;
    logic [IO_AW-1:0]  dec_io_addr, io_addr_q;
    logic [31:0]       wdata_q, data_q;
    logic [3:0]        cnt_q, wait_load;
    logic              we_q, accept, capture;

    mio_addr_decode #(
        .RAM_AW (RAM_AW),
        .IO_AW  (IO_AW)
    ) u_decode (
        .addr     (bus.addr),
        .sel      (dec_sel),
        .ram_addr (dec_ram_addr),
        .io_addr  (dec_io_addr)
    );

    assign accept  = (state_q == IDLE) && bus.CPU_MIO;
    // Read data is taken on the edge that enters RESP, whichever state precedes it.
    assign capture = (state_q != RESP) && (state_d == RESP) && !we_q;

    // Wait count for the decoded target; unmapped requests get no wait states.
    always_comb begin
        wait_load = 4'd0;
        case (dec_sel)
            RAM:     wait_load = RAM_WAIT_C;
            IO:      wait_load = IO_WAIT_C;
            default: wait_load = 4'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; CPU_MIO only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.CPU_MIO) state_d = ACCESS;
            ACCESS:  state_d = (cnt_q != 4'd0) ? WAIT : RESP;
            WAIT:    if (cnt_q <= 4'd1) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches: only the values present in the accepting IDLE cycle are used.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q      <= RAM;
            we_q       <= 1'b0;
            ram_addr_q <= '0;
            io_addr_q  <= '0;
            wdata_q    <= '0;
        end else if (accept) begin
            sel_q      <= dec_sel;
            we_q       <= bus.mem_w;
            ram_addr_q <= dec_ram_addr;
            io_addr_q  <= dec_io_addr;
            wdata_q    <= bus.data_in;
        end
    end

    // Wait-state down-counter: loaded on acceptance, decremented while in WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else if (accept) begin
            cnt_q <= wait_load;
        end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Read-data register; writes leave it untouched, unmapped reads clear it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= 32'd0;
        end else if (capture) begin
            case (sel_q)
                RAM:     data_q <= ram_rdata;
                IO:      data_q <= io_rdata;
                default: data_q <= 32'd0;
            endcase
        end
    end

    assign ram_en    = (state_q == ACCESS) && (sel_q == RAM);
    assign ram_we    = ram_en && we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = wdata_q;

    assign io_en     = (state_q == ACCESS) && (sel_q == IO);
    assign io_we     = io_en && we_q;
    assign io_addr   = io_addr_q;
    assign io_wdata  = wdata_q;

    assign bus.data_out  = data_q;
    assign bus.MIO_ready = (state_q == RESP);
`ifdef MIO_BUS_ERR_EN
    assign bus.bus_err   = (state_q == RESP) && (sel_q == NONE);
`endif

endmodule

// File: tb/tb_mio_responder.sv
// Randomized self-checking bench for mio_responder with a transaction-level model.
module tb_mio_responder;

    localparam int RAM_AW   = 10;
    localparam int IO_AW    = 4;
    localparam int RAM_WAIT = 0;
    localparam int IO_WAIT  = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ram_en, ram_we, io_en, io_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [IO_AW-1:0]  io_addr;
    logic [31:0]       ram_wdata, ram_rdata, io_wdata, io_rdata;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_data = 32'd0;
    bit          in_resp = 1'b0;

    mio_bus_if bus ();

    mio_responder #(
        .RAM_AW   (RAM_AW),
        .IO_AW    (IO_AW),
        .RAM_WAIT (RAM_WAIT),
        .IO_WAIT  (IO_WAIT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .io_en     (io_en),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata)
    );

    always #5 clk = ~clk;

    // Reference address map: 0 = RAM, 1 = IO, 2 = unmapped.
    function automatic int tgt_of(input logic [31:0] a);
        if (a[31:28] == 4'hF) return 1;
`ifdef MIO_BUS_ERR_EN
        if (a[31:RAM_AW+2] != '0) return 2;
`endif
        return 0;
    endfunction

    function automatic int wait_of(input int t);
        if (t == 0) return RAM_WAIT;
        if (t == 1) return IO_WAIT;
        return 0;
    endfunction

    // One transaction; expects the DUT idle, or in RESP when in_resp is set.
    task automatic do_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input string name);
        int   t, n;
        bit   drop_early;
        logic exp_ren, exp_ien, exp_rdy;
        t = tgt_of(a);
        n = wait_of(t);
        drop_early = 1'($urandom_range(0, 1));
        bus.CPU_MIO = 1'b1;
        bus.mem_w   = we;
        bus.addr    = a;
        bus.data_in = wd;
        ram_rdata   = (t == 1) ? ~rd : rd;
        io_rdata    = (t == 1) ? rd : ~rd;
        if (in_resp) begin
            @(posedge clk); #1;
            checks++;
            if (bus.MIO_ready !== 1'b0 || ram_en !== 1'b0 || io_en !== 1'b0)
                begin errors++; $display("FAIL %s idle_gap: ready=%b ram_en=%b io_en=%b required 0 0 0",
                                         name, bus.MIO_ready, ram_en, io_en); end
        end
        in_resp = 1'b0;
        for (int k = 1; k <= 2 + n; k++) begin
            @(posedge clk); #1;
            exp_ren = (k == 1) && (t == 0);
            exp_ien = (k == 1) && (t == 1);
            exp_rdy = (k == 2 + n);
            checks++;
            if (ram_en !== exp_ren || io_en !== exp_ien)
                begin errors++; $display("FAIL %s strobe c%0d: ram_en=%b io_en=%b required %b %b",
                                         name, k, ram_en, io_en, exp_ren, exp_ien); end
            checks++;
            if (ram_we !== (exp_ren & we) || io_we !== (exp_ien & we))
                begin errors++; $display("FAIL %s we c%0d: ram_we=%b io_we=%b required %b %b",
                                         name, k, ram_we, io_we, exp_ren & we, exp_ien & we); end
            if (exp_ren) begin
                checks++;
                if (ram_addr !== a[RAM_AW+1:2])
                    begin errors++; $display("FAIL %s ram_addr: got %h required %h", name, ram_addr, a[RAM_AW+1:2]); end
                if (we) begin
                    checks++;
                    if (ram_wdata !== wd)
                        begin errors++; $display("FAIL %s ram_wdata: got %h required %h", name, ram_wdata, wd); end
                end
            end
            if (exp_ien) begin
                checks++;
                if (io_addr !== a[IO_AW+1:2])
                    begin errors++; $display("FAIL %s io_addr: got %h required %h", name, io_addr, a[IO_AW+1:2]); end
                if (we) begin
                    checks++;
                    if (io_wdata !== wd)
                        begin errors++; $display("FAIL %s io_wdata: got %h required %h", name, io_wdata, wd); end
                end
            end
            checks++;
            if (bus.MIO_ready !== exp_rdy)
                begin errors++; $display("FAIL %s ready c%0d: got %b required %b", name, k, bus.MIO_ready, exp_rdy); end
`ifdef MIO_BUS_ERR_EN
            checks++;
            if (bus.bus_err !== (exp_rdy && t == 2))
                begin errors++; $display("FAIL %s bus_err c%0d: got %b required %b", name, k, bus.bus_err, exp_rdy && t == 2); end
`endif
            if (exp_rdy) begin
                if (!we) exp_data = (t == 2) ? 32'd0 : rd;
                checks++;
                if (bus.data_out !== exp_data)
                    begin errors++; $display("FAIL %s data_out: got %h required %h", name, bus.data_out, exp_data); end
            end
            if (k == 1) begin
                bus.addr    = $urandom;
                bus.data_in = $urandom;
                bus.mem_w   = ~we;
                if (drop_early) bus.CPU_MIO = 1'b0;
            end
        end
        bus.CPU_MIO = 1'b0;
        in_resp = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        bus.CPU_MIO = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.MIO_ready !== 1'b0 || ram_en !== 1'b0 || io_en !== 1'b0)
                begin errors++; $display("FAIL idle: ready=%b ram_en=%b io_en=%b required 0 0 0",
                                         bus.MIO_ready, ram_en, io_en); end
        end
        in_resp = 1'b0;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.CPU_MIO = 1'b1;
        bus.mem_w   = 1'b1;
        bus.addr    = 32'h0000_0010;
        bus.data_in = 32'hFFFF_FFFF;
        ram_rdata   = 32'h1111_1111;
        io_rdata    = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.MIO_ready, ram_en, ram_we, io_en, io_we} !== 5'b0)
                begin errors++; $display("FAIL reset strobes: ready/ram_en/ram_we/io_en/io_we=%b required 00000",
                                         {bus.MIO_ready, ram_en, ram_we, io_en, io_we}); end
            checks++;
            if (ram_addr !== '0 || io_addr !== '0 || ram_wdata !== '0 || io_wdata !== '0 || bus.data_out !== '0)
                begin errors++; $display("FAIL reset values: ram_addr=%h io_addr=%h ram_wdata=%h io_wdata=%h data_out=%h required all 0",
                                         ram_addr, io_addr, ram_wdata, io_wdata, bus.data_out); end
        end
        @(negedge clk);
        reset_n  = 1'b1;
        exp_data = 32'd0;
        in_resp  = 1'b0;
        do_txn(1'b0, 32'h0000_0010, 32'd0, 32'h0BAD_F00D, "reset_release");
    endtask

    task automatic test_ram_read();
        idle_cycles(1);
        do_txn(1'b0, 32'h0000_0010, 32'd0, 32'h1234_5678, "ram_read");
    endtask

    task automatic test_ram_write();
        idle_cycles(1);
        do_txn(1'b1, 32'h0000_0008, 32'hCAFE_F00D, 32'h7777_7777, "ram_write");
    endtask

    task automatic test_back_to_back_io();
        idle_cycles(2);
        do_txn(1'b1, 32'hF000_0004, 32'h0000_00A5, 32'h3333_3333, "io_write");
        do_txn(1'b0, 32'hF000_0004, 32'd0, 32'h0000_005A, "io_read");
        do_txn(1'b0, 32'h0000_0FFC, 32'd0, 32'h4444_4444, "ram_after_io");
    endtask

    task automatic test_reset_mid_op();
        idle_cycles(1);
        bus.CPU_MIO = 1'b1;
        bus.mem_w   = 1'b0;
        bus.addr    = 32'hF000_0008;
        io_rdata    = 32'h5555_5555;
        ram_rdata   = 32'h6666_6666;
        @(posedge clk); #1;
        bus.CPU_MIO = 1'b0;
        checks++;
        if (io_en !== 1'b1 || io_addr !== 4'd2)
            begin errors++; $display("FAIL midreset start: io_en=%b io_addr=%h required 1 2", io_en, io_addr); end
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        exp_data = 32'd0;
        checks++;
        if ({bus.MIO_ready, ram_en, io_en, io_we} !== 4'b0 || io_addr !== '0 || bus.data_out !== 32'd0)
            begin errors++; $display("FAIL midreset outputs: ready/ram_en/io_en/io_we=%b io_addr=%h data_out=%h required 0",
                                     {bus.MIO_ready, ram_en, io_en, io_we}, io_addr, bus.data_out); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.MIO_ready !== 1'b0)
                begin errors++; $display("FAIL midreset ready: got %b required 0", bus.MIO_ready); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(4);
        do_txn(1'b0, 32'h0000_0020, 32'd0, 32'h8888_8888, "after_midreset");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          kind;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if (kind == 0) a = a & 32'h0000_0FFF;
            else if (kind == 1) a[31:28] = 4'hF;
            else if (a[31:28] == 4'hF) a[31] = 1'b0;
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
            do_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom, "random");
        end
    endtask

`ifdef MIO_BUS_ERR_EN
    task automatic test_bus_err();
        idle_cycles(1);
        do_txn(1'b0, 32'h0000_0040, 32'd0, 32'h9999_9999, "pre_err_read");
        do_txn(1'b0, 32'h0001_0000, 32'd0, 32'hDEAD_BEEF, "err_read");
        do_txn(1'b0, 32'h0000_0044, 32'd0, 32'hABCD_0123, "pre_err_write");
        do_txn(1'b1, 32'h8000_1000, 32'h1357_9BDF, 32'hFEED_FACE, "err_write");
    endtask
`endif

    initial begin
        bus.CPU_MIO = 1'b0;
        bus.mem_w   = 1'b0;
        bus.addr    = 32'd0;
        bus.data_in = 32'd0;
        ram_rdata   = 32'd0;
        io_rdata    = 32'd0;
        reset_n     = 1'b0;
        test_reset();
        test_ram_read();
        test_ram_write();
        test_back_to_back_io();
        test_reset_mid_op();
`ifdef MIO_BUS_ERR_EN
        test_bus_err();
`endif
        test_random();
        idle_cycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
